// File: rtl/imm_ext_pkg.sv
// Shared types and instruction-field positions for the immediate-generation unit.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        IMM_DP  = 2'b00,
        IMM_MEM = 2'b01,
        IMM_BR  = 2'b10,
        IMM_S12 = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ROT  = 2'b01,
        HOLD = 2'b10
    } state_e;

    localparam int unsigned ROT_LSB  = 8;
    localparam int unsigned ROT_MSB  = 11;
    localparam int unsigned IMM8_MSB = 7;
    localparam int unsigned BR_MSB   = 23;

    // Rotate distance is 2 * rot4, so at most 30.
    localparam int unsigned RCNT_W = 5;

    function automatic logic [RCNT_W-1:0] rot_amount(input logic [ROT_MSB-ROT_LSB:0] rot4);
        return {rot4, 1'b0};
    endfunction

endpackage

// File: rtl/imm_rot_step.sv
// Combinational rotate-right of DATA_W bits by 0..ROT_STEP positions.
module imm_rot_step #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ROT_STEP = 8
) (
    input  logic [DATA_W-1:0]          din,
    input  logic [$clog2(ROT_STEP):0]  amt,
    output logic [DATA_W-1:0]          dout
);

    logic [31:0] lsh;

    // A left shift by DATA_W yields zero, so amt == 0 passes din through.
    assign lsh  = DATA_W - 32'(amt);
    assign dout = (din >> amt) | (din << lsh);

endmodule

// File: rtl/imm_ext_unit.sv
// Handshaked immediate generator with iterative DP rotation.
// Define IMM_EXT_CARRY_EN to add the rot_carry shifter carry-out port.
module imm_ext_unit
    import imm_ext_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ROT_STEP = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        imm_src,
    input  logic [23:0]       imm_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm_out,
    output logic              busy
`ifdef IMM_EXT_CARRY_EN
    ,
    output logic              rot_carry
`endif
);

    localparam int unsigned SW = $clog2(ROT_STEP) + 1;

    state_e            state;
    logic [DATA_W-1:0] work;
    logic [DATA_W-1:0] pre;
    logic [DATA_W-1:0] rotated;
    logic [RCNT_W-1:0] rem;
    logic [RCNT_W-1:0] rem_load;
    logic [RCNT_W-1:0] rem_next;
    logic [SW-1:0]     step;
    logic              accept;

    always_comb begin
        in_ready = 1'b0;
        unique case (state)
            IDLE:    in_ready = 1'b1;
            ROT:     in_ready = 1'b0;
            HOLD:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        pre      = '0;
        rem_load = '0;
        unique case (imm_src_e'(imm_src))
            IMM_DP: begin
                pre      = {{(DATA_W-IMM8_MSB-1){1'b0}}, imm_in[IMM8_MSB:0]};
                rem_load = rot_amount(imm_in[ROT_MSB:ROT_LSB]);
            end
            IMM_MEM: pre = {{(DATA_W-12){1'b0}}, imm_in[11:0]};
            IMM_BR:  pre = {{(DATA_W-BR_MSB-3){imm_in[BR_MSB]}}, imm_in[BR_MSB:0], 2'b00};
            IMM_S12: pre = {{(DATA_W-12){imm_in[11]}}, imm_in[11:0]};
            default: pre = '0;
        endcase
    end

    always_comb begin
        if (32'(rem) > ROT_STEP) step = SW'(ROT_STEP);
        else                     step = SW'(rem);
    end

    assign rem_next = rem - RCNT_W'(step);

    imm_rot_step #(
        .DATA_W   (DATA_W),
        .ROT_STEP (ROT_STEP)
    ) u_rot_step (
        .din  (work),
        .amt  (step),
        .dout (rotated)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            work      <= '0;
            rem       <= '0;
            imm_out   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            // Covers both a fresh request in IDLE and consume-plus-accept in HOLD.
            work <= pre;
            rem  <= rem_load;
            if (rem_load != '0) begin
                state     <= ROT;
                busy      <= 1'b1;
                out_valid <= 1'b0;
            end else begin
                state     <= HOLD;
                imm_out   <= pre;
                out_valid <= 1'b1;
            end
        end else begin
            unique case (state)
                ROT: begin
                    work <= rotated;
                    rem  <= rem_next;
                    if (rem_next == '0) begin
                        state     <= HOLD;
                        imm_out   <= rotated;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IMM_EXT_CARRY_EN
    // Only a finished nonzero DP rotation produces a carry; every load clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rot_carry <= 1'b0;
        end else if (accept) begin
            rot_carry <= 1'b0;
        end else if (state == ROT && rem_next == '0) begin
            rot_carry <= rotated[DATA_W-1];
        end
    end
`else
    // Without the carry port the rotator result feeds imm_out only.
`endif

endmodule

// File: tb/tb_imm_ext_unit.sv
// Directed bench for imm_ext_unit: vector table plus reset, streaming and backpressure sequences.
module tb_imm_ext_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  imm_src;
    logic [23:0] imm_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] imm_out;
    logic        busy;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [1:0]  w_imm_src;
    logic [23:0] w_imm_in;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [63:0] w_imm_out;
    logic        w_busy;
`ifdef IMM_EXT_CARRY_EN
    logic        rot_carry;
    logic        w_rot_carry;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_ext_unit #(.DATA_W(32), .ROT_STEP(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_src   (imm_src),
        .imm_in    (imm_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm_out   (imm_out),
        .busy      (busy)
`ifdef IMM_EXT_CARRY_EN
        ,
        .rot_carry (rot_carry)
`endif
    );

    imm_ext_unit #(.DATA_W(64), .ROT_STEP(2)) dut_w (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .imm_src   (w_imm_src),
        .imm_in    (w_imm_in),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .imm_out   (w_imm_out),
        .busy      (w_busy)
`ifdef IMM_EXT_CARRY_EN
        ,
        .rot_carry (w_rot_carry)
`endif
    );

    typedef struct {
        logic [1:0]  src;
        logic [23:0] imm;
        logic [31:0] val;
        int          lat;
        logic        carry;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge with the main DUT idle and out_ready high.
    task automatic apply(input int idx, input vec_t v);
        int lat;
        int bcnt;
        in_valid = 1'b1;
        imm_src  = v.src;
        imm_in   = v.imm;
        @(negedge clk);
        check($sformatf("v%0d_in_ready", idx), 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        imm_src  = ~v.src;
        imm_in   = ~v.imm;
        lat  = 0;
        bcnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.lat));
        check($sformatf("v%0d_busy_cycles", idx), 64'(bcnt), 64'(v.lat - 1));
        check($sformatf("v%0d_imm_out", idx), 64'(imm_out), 64'(v.val));
`ifdef IMM_EXT_CARRY_EN
        check($sformatf("v%0d_rot_carry", idx), 64'(rot_carry), 64'(v.carry));
`endif
        @(posedge clk);
        #1;
    endtask

    logic [31:0] stream_exp[3];
    logic [1:0]  stream_src[3];
    logic [23:0] stream_imm[3];

    initial begin
        int seen;
        int lat;
        int bcnt;

        vecs[0] = '{2'b00, 24'h0004FF, 32'hFF000000, 2, 1'b1};
        vecs[1] = '{2'b00, 24'h000F01, 32'h00000004, 5, 1'b0};
        vecs[2] = '{2'b00, 24'hFFF0AB, 32'h000000AB, 1, 1'b0};
        vecs[3] = '{2'b01, 24'h123FFF, 32'h00000FFF, 1, 1'b0};
        vecs[4] = '{2'b10, 24'h800000, 32'hFE000000, 1, 1'b0};
        vecs[5] = '{2'b10, 24'h000001, 32'h00000004, 1, 1'b0};
        vecs[6] = '{2'b11, 24'hABC7FF, 32'h000007FF, 1, 1'b0};
        vecs[7] = '{2'b11, 24'h000800, 32'hFFFFF800, 1, 1'b0};
        vecs[8] = '{2'b00, 24'h000102, 32'h80000000, 2, 1'b1};
        vecs[9] = '{2'b00, 24'h000A7F, 32'h0007F000, 4, 1'b0};

        stream_src = '{2'b01, 2'b11, 2'b10};
        stream_imm = '{24'h000800, 24'h000800, 24'hFFFFFE};
        stream_exp = '{32'h00000800, 32'hFFFFF800, 32'hFFFFFFF8};

        reset       = 1'b1;
        in_valid    = 1'b0;
        imm_src     = 2'b00;
        imm_in      = '0;
        out_ready   = 1'b1;
        w_in_valid  = 1'b0;
        w_imm_src   = 2'b00;
        w_imm_in    = '0;
        w_out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_imm_out", 64'(imm_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_w_imm_out", w_imm_out, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) apply(i, vecs[i]);

        // Back-to-back streaming, one request per cycle.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            imm_src  = stream_src[i];
            imm_in   = stream_imm[i];
            @(negedge clk);
            check($sformatf("stream%0d_in_ready", i), 64'(in_ready), 64'd1);
            if (i > 0) begin
                check($sformatf("stream%0d_valid", i - 1), 64'(out_valid), 64'd1);
                check($sformatf("stream%0d_imm_out", i - 1), 64'(imm_out), 64'(stream_exp[i - 1]));
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream2_valid", 64'(out_valid), 64'd1);
        check("stream2_imm_out", 64'(imm_out), 64'(stream_exp[2]));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("stream_drain_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Backpressure: hold for 3 cycles with the next request already waiting.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        imm_src   = 2'b01;
        imm_in    = 24'h000055;
        @(posedge clk);
        #1;
        imm_src = 2'b11;
        imm_in  = 24'h000FFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("bp%0d_imm_out", i), 64'(imm_out), 64'h55);
            check($sformatf("bp%0d_in_ready", i), 64'(in_ready), 64'd0);
            if (i < 2) @(posedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_valid", 64'(out_valid), 64'd1);
        check("bp_next_imm_out", 64'(imm_out), 64'hFFFFFFFF);
        @(posedge clk);
        #1;

        // Reset during the second ROT cycle of DP 0xF01.
        in_valid = 1'b1;
        imm_src  = 2'b00;
        imm_in   = 24'h000F01;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rrot_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rrot_out_valid", 64'(out_valid), 64'd0);
        check("rrot_imm_out", 64'(imm_out), 64'd0);
        check("rrot_busy", 64'(busy), 64'd0);
        check("rrot_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rrot_no_stale_result", 64'(seen), 64'd0);
        check("rrot_idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Wide instance: DATA_W 64, ROT_STEP 2.
        w_in_valid = 1'b1;
        w_imm_src  = 2'b00;
        w_imm_in   = 24'h0001FF;
        @(negedge clk);
        check("w_in_ready", 64'(w_in_ready), 64'd1);
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        lat  = 0;
        bcnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (w_busy) bcnt++;
            if (w_out_valid) begin
                lat = k;
                break;
            end
        end
        check("w_latency", 64'(lat), 64'd2);
        check("w_busy_cycles", 64'(bcnt), 64'd1);
        check("w_imm_out", w_imm_out, 64'hC00000000000003F);
`ifdef IMM_EXT_CARRY_EN
        check("w_rot_carry", 64'(w_rot_carry), 64'd1);
`endif
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_ext_unit.md
Name: imm_ext_unit

Overview:
- Parametrised, handshaked immediate-generation unit for the decode stage.
- Replaces the single-mode 12-bit sign extender with four selectable extension modes, including ARM data-processing rotated immediates.
- Rotation runs iteratively: ROT_STEP bits per cycle through a small FSM, trading latency for shifter area.
- Results are held in an output register under valid/ready flow control until the datapath consumes them.

Parameters:
- DATA_W, 32: result width; must be >= 32.
- ROT_STEP, 8: maximum right-rotate distance per cycle; even, power of two, 2..DATA_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit accepts a request this cycle.
- imm_src  input  2  extension mode (see Behaviour).
- imm_in  input  24  raw instruction immediate field, Instr[23:0].
- out_valid  output  1  imm_out holds a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- imm_out  output  DATA_W  extended immediate.
- busy  output  1  high in ROT state.

Behaviour:
- Modes:
  - 00 DP: imm8 = imm_in[7:0], zero-extended to DATA_W, rotated right by R = 2*imm_in[11:8], rotation within DATA_W.
  - 01 MEM: zero-extend imm_in[11:0].
  - 10 BR: sign-extend imm_in[23:0] (bit 23), then shift left 2; the upper bits follow the sign.
  - 11 S12: sign-extend imm_in[11:0] (bit 11).
- Reset values: state IDLE; out_valid 0; imm_out 0; busy 0; internal work register and remaining count 0. A reset during ROT or HOLD discards the operation; no output is produced for it.
- States:
  - IDLE: in_ready = 1.
  - ROT: in_ready = 0; busy = 1.
  - HOLD: out_valid = 1; in_ready = out_ready.
- Accept occurs when in_valid && in_ready at a clock edge:
  - The work register loads the mode's pre-rotate value; the remaining count loads R in DP mode, else 0.
  - If the remaining count is nonzero, next state is ROT; otherwise next state is HOLD, with imm_out = the value.
- ROT, each cycle: rotate the work register right by min(ROT_STEP, remaining) and decrement remaining by the same amount. When remaining reaches 0, load imm_out and go to HOLD.
- Latency from the accept edge to out_valid: 1 cycle when R = 0 or the mode is non-DP; otherwise 1 + ceil(R/ROT_STEP) cycles.
- HOLD:
  - out_ready = 0: hold; imm_out and out_valid stable.
  - out_ready = 1 with no accept: return to IDLE; out_valid falls next cycle.
  - out_ready = 1 and in_valid = 1 in the same cycle: consume and accept simultaneously. Next state is HOLD or ROT per the new request. This gives throughput of 1 per cycle for non-rotating requests.
- Inputs are sampled only on accept; changes to imm_src or imm_in afterwards have no effect.
- imm_in bits that the selected mode does not use are ignored.

Optional Feature:
- Macro IMM_EXT_CARRY_EN.
- Defined: adds output port rot_carry (1 bit), registered alongside imm_out. It equals imm_out[DATA_W-1] when the mode is DP and R != 0, else 0. This is the shifter carry-out for flag logic.
- Undefined: port and logic absent; all other behaviour is identical.

Decomposition:
- Package imm_ext_pkg:
  - imm_src_e enum: IMM_DP, IMM_MEM, IMM_BR, IMM_S12.
  - state_e enum: IDLE, ROT, HOLD.
  - Field constants: ROT_LSB = 8, ROT_MSB = 11, IMM8_MSB = 7, BR_MSB = 23.
- One sub-module, imm_rot_step: combinational rotate-right of DATA_W bits by a variable amount 0..ROT_STEP.

Test Plan:
- Reset mid-ROT: DP 0xF01, assert reset during the second ROT cycle -> out_valid 0, imm_out 0, state IDLE, in_ready 1; no stale result appears afterwards.
- DP rotation, two cases with ROT_STEP = 8:
  - imm_src 00, imm_in 0x0004FF -> out_valid 2 cycles after accept, imm_out 0xFF000000.
  - imm_src 00, imm_in 0x000F01 -> 5 cycles, imm_out 0x00000004, busy high for 4 cycles.
- Back-to-back streaming with out_ready held 1: MEM 0x800, S12 0x800, BR 0xFFFFFE presented on consecutive cycles -> results 0x00000800, 0xFFFFF800, 0xFFFFFFF8 on consecutive cycles; in_ready never drops.
- Backpressure: out_ready = 0 for 3 cycles in HOLD -> imm_out stable, in_ready 0; on release, a new request is accepted in the same cycle.
- Parameter sweep: DATA_W 64 with ROT_STEP 2, DP 0x0001FF -> imm_out 0xC00000000000003F after 1 ROT cycle. With IMM_EXT_CARRY_EN defined -> rot_carry 1.
